clock_set_ctrl: RTL
===================

# clock_set_ctrl

- Button-driven setting controller for the digital alarm clock.
- Debounces three raw push-buttons and walks an edit FSM through hours, then minutes, in BCD.
- Drives the clock's time/alarm load interface: BCD digits plus an `LD_time`/`LD_alarm` strobe held long enough for the clock's slow 1 s domain to sample it.
- Sits between the board buttons and the clock's `H_in*`/`M_in*`/`LD_*` inputs; the edit status outputs feed the display blinker.

## Interface
- `DB_CYCLES`, 20000: consecutive stable `clk` cycles required before a debounced level changes (≥1).
- `LD_HOLD`, 10: number of `clk` cycles a load strobe stays high (≥ one clock `clk_1s` period).
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `btn_mode` in 1: raw button, active-high, asynchronous to `clk`.
- `btn_inc` in 1: raw button, active-high.
- `btn_alm` in 1: raw button, active-high.
- `cur_h1` in 2, `cur_h0` in 4, `cur_m1` in 3, `cur_m0` in 4: current clock time in BCD, used to seed a time edit.
- `H_set1` out 2, `H_set0` out 4, `M_set1` out 3, `M_set0` out 4: BCD hour/minute to the clock's `H_in*`/`M_in*`.
- `LD_time` out 1: time-load strobe.
- `LD_alarm` out 1: alarm-load strobe.
- `edit_active` out 1: high in `EDIT_H` and `EDIT_M`.
- `edit_field` out 2: 0 = none, 1 = hours, 2 = minutes.

## Operation
- **Input conditioning**
  - Each button passes through a 2-flop synchronizer.
  - A per-button counter changes the debounced level only after `DB_CYCLES` consecutive cycles of a synchronized value differing from it.
  - A press is a one-cycle pulse on the debounced 0→1 edge; releases generate nothing.
- **Press priority** (same cycle): `alm` > `mode` > `inc`. Only the highest is acted on; the others are discarded.
- **Edit registers:** four BCD digits `eh1`, `eh0`, `em1`, `em0`, plus a `target` bit (TIME/ALARM). The `*_set` outputs are driven directly from these registers in every state.
- **Alarm shadow:** four BCD digits, updated only on an alarm load.
- **FSM**
  - `IDLE`
    - `mode` press → `EDIT_H`, target = TIME, edit registers ← `cur_*`.
    - `alm` press → `EDIT_H`, target = ALARM, edit registers ← alarm shadow.
    - `inc` press ignored.
  - `EDIT_H`
    - `inc` press: hour = hour + 1 in BCD, 23→00.
    - `mode` press → `EDIT_M`.
    - `alm` press → `IDLE` (cancel; no strobe, edit registers keep their values).
  - `EDIT_M`
    - `inc` press: minute = minute + 1 in BCD, 59→00, no carry into hours.
    - `mode` press → `LOAD`.
    - `alm` press → `IDLE` (cancel).
  - `LOAD`
    - Asserts `LD_time` (TIME) or `LD_alarm` (ALARM) for exactly `LD_HOLD` cycles, digits held stable.
    - Then → `IDLE`. For ALARM, the alarm shadow ← edit registers on entry to `LOAD`.
    - All presses are discarded in `LOAD`.
- **BCD rules**
  - Carry from the units digit into the tens digit.
  - A seeded invalid value (hour > 23, or any digit > 9, or minute tens > 5) wraps to 00 on the next `inc`; otherwise it is passed through unchanged.
- **Strobe exclusivity:** `LD_time` and `LD_alarm` are never high together.

## Timing
- **Reset (`reset` = 0), asynchronous:**
  - State `IDLE`; all `*_set` = 0, `LD_time` = `LD_alarm` = 0, `edit_active` = 0, `edit_field` = 0.
  - Alarm shadow = 00:00; debounced levels = 0; counters = 0.
- **Reset mid-`LOAD`:** strobe drops immediately, no completion after release.
- **Press latency:** raw high first sampled at edge 0 and held stable → press pulse high during the cycle after edge `DB_CYCLES+2`. The resulting state/digit change is visible after the next edge.
- **Bounce:** any glitch shorter than `DB_CYCLES` cycles produces no press.
- **Strobe timing:** `LD_*` rises on the edge entering `LOAD` and falls `LD_HOLD` edges later, on the same edge that returns to `IDLE`.
- **Outputs:** `edit_active` and `edit_field` are registered with the state; no combinational path from buttons to outputs.

## Test plan
Benches use `DB_CYCLES`=4 and `LD_HOLD`=3.

1. **Reset:** `reset`=0 with buttons toggling → all outputs 0. Release reset → still 0 and `IDLE`.
2. **Debounce:** `btn_inc` pulses of 3 cycles repeated in `EDIT_H` → hour unchanged. A clean 10-cycle press → hour +1 exactly once, 6 cycles after the first high sample.
3. **Time set:** `cur`=22:58.
   - `mode` → `edit_field`=1.
   - `inc`×2 → `H_set`=00.
   - `mode` → `edit_field`=2.
   - `inc`×2 → `M_set`=00 (59→00), hour still 00.
   - `mode` → `LD_time` high 3 cycles with 00:00, `LD_alarm` stays 0.
4. **Alarm set then re-edit:** `alm`, `inc`×7, `mode`, `inc`×30, `mode` → `LD_alarm` 3 cycles with 07:30. A second `alm` press seeds 07:30.
5. **Cancel and priority:**
   - `alm` press in `EDIT_M` → `IDLE`, no strobe.
   - `mode` and `inc` debounced the same cycle in `EDIT_H` → `EDIT_M`, hour unchanged.
6. **Abort and invalid seed:**
   - `reset` asserted on the 2nd `LOAD` cycle → `LD_time` 0 at once.
   - `cur`=29:61 seeded, then `inc` → hour 00; `mode`, `inc` → minute 00.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: debounced three-button setting controller for the alarm clock.
// Edits hours then minutes in BCD and issues a held time/alarm load strobe.
`default_nettype none

module clock_set_ctrl #(
    parameter int DB_CYCLES = 20000,
    parameter int LD_HOLD   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_alm,
    input  logic [1:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [2:0] cur_m1,
    input  logic [3:0] cur_m0,
    output logic [1:0] H_set1,
    output logic [3:0] H_set0,
    output logic [2:0] M_set1,
    output logic [3:0] M_set0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       edit_active,
    output logic [1:0] edit_field
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int HW = (LD_HOLD > 1) ? $clog2(LD_HOLD) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EDIT_H = 2'd1,
        S_EDIT_M = 2'd2,
        S_LOAD   = 2'd3
    } state_t;

    // index 0 = inc, 1 = mode, 2 = alm
    logic [2:0] w_btn;
    logic [2:0] w_press;
    assign w_btn = {btn_alm, btn_mode, btn_inc};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic [1:0]    r_sync;
        logic [CW-1:0] r_cnt;
        logic          r_db;
        logic          r_db_d;
        logic          r_pr;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync <= 2'b00;
                r_cnt  <= '0;
                r_db   <= 1'b0;
                r_db_d <= 1'b0;
                r_pr   <= 1'b0;
            end else begin
                r_sync <= {r_sync[0], w_btn[i]};
                r_db_d <= r_db;
                r_pr   <= r_db & ~r_db_d;
                if (r_sync[1] == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
                    r_db  <= r_sync[1];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_press[i] = r_pr;
    end

    function automatic logic [5:0] f_inc_hour(input logic [1:0] h1, input logic [3:0] h0);
        logic [5:0] v;
        if (h0 > 4'd9 || h1 > 2'd2 || (h1 == 2'd2 && h0 >= 4'd3)) v = 6'h00;
        else if (h0 == 4'd9)                                     v = {h1 + 2'd1, 4'd0};
        else                                                      v = {h1, h0 + 4'd1};
        return v;
    endfunction

    function automatic logic [6:0] f_inc_min(input logic [2:0] m1, input logic [3:0] m0);
        logic [6:0] v;
        if (m0 > 4'd9 || m1 > 3'd5 || (m1 == 3'd5 && m0 == 4'd9)) v = 7'h00;
        else if (m0 == 4'd9)                                     v = {m1 + 3'd1, 4'd0};
        else                                                      v = {m1, m0 + 4'd1};
        return v;
    endfunction

    state_t        r_state, w_state;
    logic          r_target, w_target;       // 0 = time, 1 = alarm
    logic [5:0]    r_eh, w_eh;
    logic [6:0]    r_em, w_em;
    logic [5:0]    r_ah, w_ah;
    logic [6:0]    r_am, w_am;
    logic [HW-1:0] r_hold, w_hold;
    logic          w_alm, w_mode, w_inc;

    assign w_alm  = w_press[2];
    assign w_mode = w_press[1] & ~w_press[2];
    assign w_inc  = w_press[0] & ~w_press[1] & ~w_press[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_target <= 1'b0;
            r_eh     <= '0;
            r_em     <= '0;
            r_ah     <= '0;
            r_am     <= '0;
            r_hold   <= '0;
        end else begin
            r_state  <= w_state;
            r_target <= w_target;
            r_eh     <= w_eh;
            r_em     <= w_em;
            r_ah     <= w_ah;
            r_am     <= w_am;
            r_hold   <= w_hold;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_target = r_target;
        w_eh     = r_eh;
        w_em     = r_em;
        w_ah     = r_ah;
        w_am     = r_am;
        w_hold   = r_hold;
        case (r_state)
            S_IDLE: begin
                if (w_alm) begin
                    w_state  = S_EDIT_H;
                    w_target = 1'b1;
                    w_eh     = r_ah;
                    w_em     = r_am;
                end else if (w_mode) begin
                    w_state  = S_EDIT_H;
                    w_target = 1'b0;
                    w_eh     = {cur_h1, cur_h0};
                    w_em     = {cur_m1, cur_m0};
                end
            end
            S_EDIT_H: begin
                if (w_alm)       w_state = S_IDLE;
                else if (w_mode) w_state = S_EDIT_M;
                else if (w_inc)  w_eh    = f_inc_hour(r_eh[5:4], r_eh[3:0]);
            end
            S_EDIT_M: begin
                if (w_alm) begin
                    w_state = S_IDLE;
                end else if (w_mode) begin
                    w_state = S_LOAD;
                    w_hold  = '0;
                    if (r_target) begin
                        w_ah = r_eh;
                        w_am = r_em;
                    end
                end else if (w_inc) begin
                    w_em = f_inc_min(r_em[6:4], r_em[3:0]);
                end
            end
            default: begin
                // LOAD: presses are dropped while the strobe is held
                if (r_hold == HW'(LD_HOLD - 1)) w_state = S_IDLE;
                else                             w_hold  = r_hold + 1'b1;
            end
        endcase
    end

    assign H_set1      = r_eh[5:4];
    assign H_set0      = r_eh[3:0];
    assign M_set1      = r_em[6:4];
    assign M_set0      = r_em[3:0];
    assign LD_time     = (r_state == S_LOAD) && !r_target;
    assign LD_alarm    = (r_state == S_LOAD) &&  r_target;
    assign edit_active = (r_state == S_EDIT_H) || (r_state == S_EDIT_M);
    assign edit_field  = (r_state == S_EDIT_H) ? 2'd1 :
                         (r_state == S_EDIT_M) ? 2'd2 : 2'd0;

endmodule

`default_nettype wire
